// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multi-channel memory front-end:
// per-channel state encoding and the XOR fold used to build the coverage index.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      READY_S   = 2'd0,
      PENDING_S = 2'd1,
      BUSY_S    = 2'd2
   } chan_state_e;

   localparam int FOLD_MAX = 64;

   // Folds v onto w bits by XOR-ing bit i into bit (i mod w).
   function automatic logic [31:0] xor_fold(input logic [FOLD_MAX-1:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < FOLD_MAX; i++) begin
         r[i % w] = r[i % w] ^ v[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_ctrl_chan.sv
// One input channel: gathers BEATS beats into a word, then holds it (BUSY)
// until the arbiter releases it. Optional state port under MEM_CTRL_MULTI_COV_EN.
module mem_ctrl_chan
   import mem_ctrl_pkg::*;
#(
   parameter int BEAT_W = 4,
   parameter int BEATS  = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      beat_valid,
   input  logic [BEAT_W-1:0]         beat_data,
   input  logic                      release_en,
`ifdef MEM_CTRL_MULTI_COV_EN
   output chan_state_e               state,
`endif
   output logic                      ready,
   output logic                      busy,
   output logic [BEAT_W*BEATS-1:0]   word
);

   localparam int OUT_W = BEAT_W * BEATS;
   localparam int CNT_W = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   chan_state_e      st;
   logic [CNT_W-1:0] cnt;

   assign ready = (st != BUSY_S);
   assign busy  = (st == BUSY_S);
`ifdef MEM_CTRL_MULTI_COV_EN
   assign state = st;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of its neighbours regardless of order.
   always_ff @(posedge clock) begin
      if (reset) begin
         st   <= READY_S;
         cnt  <= '0;
         word <= '0;
      end else begin
         case (st)
            READY_S: begin
               if (beat_valid) begin
                  word <= OUT_W'(beat_data);
                  cnt  <= CNT_W'(1);
                  st   <= (BEATS == 1) ? BUSY_S : PENDING_S;
               end
            end
            PENDING_S: begin
               if (beat_valid) begin
                  word[int'(cnt)*BEAT_W +: BEAT_W] <= word[int'(cnt)*BEAT_W +: BEAT_W] | beat_data;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) st <= BUSY_S;
               end
            end
            BUSY_S: begin
               // Word is frozen; incoming beats are refused via ready.
               if (release_en) begin
                  st  <= READY_S;
                  cnt <= '0;
               end
            end
            default: begin
               st  <= READY_S;
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_ctrl_multi.sv
// Multi-channel beat assembler with round-robin output arbiter and "bug" flag.
// Define MEM_CTRL_MULTI_COV_EN to enable the cumulative state-tuple coverage counter.
module mem_ctrl_multi
   import mem_ctrl_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int BEAT_W = 4,
   parameter int BEATS  = 2,
   parameter int COV_W  = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           in_valid,
   input  logic [NUM_CH*BEAT_W-1:0]    in_data,
   output logic [NUM_CH-1:0]           in_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BEAT_W*BEATS-1:0]     out_data,
   output logic [$clog2(NUM_CH)-1:0]   out_ch,
   output logic [COV_W:0]              coverage,
   output logic                        bug
);

   localparam int OUT_W = BEAT_W * BEATS;
   localparam int CH_W  = $clog2(NUM_CH);

   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] release_en;
   logic [OUT_W-1:0]  words [NUM_CH];
`ifdef MEM_CTRL_MULTI_COV_EN
   chan_state_e       st [NUM_CH];
`endif

   logic [CH_W-1:0]   rr;
   logic              hold;
   logic [CH_W-1:0]   hold_ch;
   logic [CH_W-1:0]   grant;
   logic              handshake;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      mem_ctrl_chan #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_chan (
         .clock      (clock),
         .reset      (reset),
         .beat_valid (in_valid[c]),
         .beat_data  (in_data[c*BEAT_W +: BEAT_W]),
         .release_en (release_en[c]),
`ifdef MEM_CTRL_MULTI_COV_EN
         .state      (st[c]),
`endif
         .ready      (in_ready[c]),
         .busy       (busy[c]),
         .word       (words[c])
      );
      assign release_en[c] = handshake && (grant == CH_W'(c));
   end

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      int  idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      if (hold) begin
         grant = hold_ch;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && busy[idx]) begin
               found = 1'b1;
               grant = CH_W'(idx);
            end
         end
      end
   end

   assign out_valid = |busy;
   assign handshake = out_valid && out_ready;
   assign out_data  = out_valid ? words[grant] : '0;
   assign out_ch    = out_valid ? grant : '0;
   assign bug       = &busy;

   // A stalled grant is remembered so later BUSY channels cannot steal the port.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr      <= '0;
         hold    <= 1'b0;
         hold_ch <= '0;
      end else begin
         hold    <= out_valid && !out_ready;
         hold_ch <= grant;
         if (handshake) rr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
   end

`ifdef MEM_CTRL_MULTI_COV_EN
   localparam int COV_N = 2 ** COV_W;

   logic [2*NUM_CH-1:0] state_cat;
   logic [2*NUM_CH-1:0] state_q = '0;
   logic [COV_W-1:0]    cov_idx;
   // NOTE: covmap/covsum start at zero once and are deliberately left out of
   // reset so that coverage accumulates across back-to-back tests.
   logic [COV_N-1:0]    covmap = '0;
   logic [COV_W:0]      covsum = '0;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_cat
      assign state_cat[2*c +: 2] = st[c];
   end

   assign cov_idx = COV_W'(xor_fold(FOLD_MAX'(state_q), COV_W));

   always_ff @(posedge clock) begin
      state_q <= state_cat;
      if (!covmap[cov_idx]) begin
         covmap[cov_idx] <= 1'b1;
         if (covsum != (COV_W + 1)'(COV_N)) covsum <= covsum + 1'b1;
      end
   end

   assign coverage = covsum;
`else
   assign coverage = '0;
`endif

endmodule
